// File: rtl/csr_trap_ctrl.sv
// Sequencer between decode and the machine-mode CSR file: runs one CSR
// read-modify-write, ecall or mret at a time and hands back rd data / PC redirect.
module csr_trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic            is_ecall_i,
    input  logic            is_mret_i,
    input  logic            is_csr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] src1_i,
    output logic [11:0]     csr_addr_o,
    input  logic [XLEN-1:0] csr_rdata_i,
    output logic            csr_wen_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            csr_ecall_o,
    output logic            csr_mret_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mcause_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            rd_wen_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            illegal_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, RET, DONE} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, src1_q, rd_data_q, redirect_pc_q;
    logic [1:0]      op_q;
    logic [11:0]     addr_q, csr_addr_q;
    logic            rd_wen_q, redirect_q, illegal_q;
    logic            accept, addr_legal, csr_legal, wr_suppress;
    logic [XLEN-1:0] new_val;

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; valid holds its payload stable until that edge.
    assign in_ready_o = (state_q == IDLE) && !rst_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        addr_legal = 1'b0;
        case (addr_q)
            12'h300, 12'h305, 12'h341, 12'h342: addr_legal = 1'b1;
            default:                            addr_legal = 1'b0;
        endcase
    end

    assign csr_legal   = addr_legal && (op_q != 2'b11);
    // Set/clear with a zero mask leave the CSR untouched, so no write strobe.
    assign wr_suppress = (op_q != 2'b00) && (src1_q == '0);

    always_comb begin
        new_val = src1_q;
        case (op_q)
            2'b00:   new_val = src1_q;
            2'b01:   new_val = rd_data_q | src1_q;
            default: new_val = rd_data_q & ~src1_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_ecall_i)     state_d = TRAP;
                    else if (is_mret_i) state_d = RET;
                    else if (is_csr_i)  state_d = READ;
                    else                state_d = DONE;
                end
            end
            READ:              state_d = csr_legal ? WRITE : DONE;
            WRITE, TRAP, RET:  state_d = DONE;
            DONE:              if (out_ready_i) state_d = IDLE;
            default:           state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q          <= '0;
            src1_q        <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            csr_addr_q    <= '0;
            rd_data_q     <= '0;
            rd_wen_q      <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            illegal_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pc_q          <= pc_i;
                        src1_q        <= src1_i;
                        op_q          <= csr_op_i;
                        addr_q        <= csr_addr_i;
                        rd_data_q     <= '0;
                        rd_wen_q      <= 1'b0;
                        redirect_q    <= 1'b0;
                        redirect_pc_q <= '0;
                        illegal_q     <= 1'b0;
                        // The CSR address bus only moves when a CSR access follows.
                        if (is_ecall_i)     csr_addr_q <= 12'h305;
                        else if (is_mret_i) csr_addr_q <= 12'h341;
                        else if (is_csr_i)  csr_addr_q <= csr_addr_i;
                    end
                end
                READ: begin
                    if (csr_legal) begin
                        rd_data_q <= csr_rdata_i;
                        rd_wen_q  <= 1'b1;
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
                TRAP: begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_rdata_i & ~XLEN'(3);
                end
                RET: begin
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= csr_rdata_i;
                end
                default: ;
            endcase
        end
    end

    assign csr_addr_o       = csr_addr_q;
    assign csr_wen_o        = ((state_q == WRITE) && !wr_suppress) || (state_q == TRAP) || (state_q == RET);
    assign csr_wdata_o      = (state_q == WRITE) ? new_val : '0;
    assign csr_ecall_o      = (state_q == TRAP);
    assign csr_mret_o       = (state_q == RET);
    assign mepc_o           = (state_q == TRAP) ? pc_q : '0;
    assign mcause_o         = (state_q == TRAP) ? XLEN'(ECALL_CAUSE) : '0;
    assign out_valid_o      = (state_q == DONE);
    assign rd_wen_o         = (state_q == DONE) && rd_wen_q;
    assign rd_data_o        = (state_q == DONE) ? rd_data_q : '0;
    assign redirect_valid_o = (state_q == DONE) && redirect_q;
    assign redirect_pc_o    = (state_q == DONE) ? redirect_pc_q : '0;
    assign illegal_o        = (state_q == DONE) && illegal_q;
    assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a small CSR file model drives csr_rdata_i and
// absorbs writes; a spec-level instruction model predicts every result.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] pc = '0, src1 = '0;
    logic        is_ecall = 1'b0, is_mret = 1'b0, is_csr = 1'b0;
    logic [1:0]  csr_op = '0;
    logic [11:0] csr_addr_in = '0, csr_addr;
    logic [31:0] csr_rdata, csr_wdata, mepc, mcause;
    logic        csr_wen, csr_ecall, csr_mret;
    logic        out_valid, out_ready = 1'b0;
    logic        rd_wen, redirect_valid, illegal, busy;
    logic [31:0] rd_data, redirect_pc;

    always #5 clk = ~clk;

    csr_trap_ctrl #(.XLEN(32), .ECALL_CAUSE(11)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc), .is_ecall_i(is_ecall), .is_mret_i(is_mret), .is_csr_i(is_csr),
        .csr_op_i(csr_op), .csr_addr_i(csr_addr_in), .src1_i(src1),
        .csr_addr_o(csr_addr), .csr_rdata_i(csr_rdata),
        .csr_wen_o(csr_wen), .csr_wdata_o(csr_wdata),
        .csr_ecall_o(csr_ecall), .csr_mret_o(csr_mret),
        .mepc_o(mepc), .mcause_o(mcause),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .rd_wen_o(rd_wen), .rd_data_o(rd_data),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc),
        .illegal_o(illegal), .busy_o(busy)
    );

    int total = 0;
    int bad   = 0;

    // CSR file: 0=mstatus 0x300, 1=mtvec 0x305, 2=mepc 0x341, 3=mcause 0x342
    logic [31:0] csr_file [4];
    logic [31:0] ref_mem  [4];
    logic        pl_en = 1'b0;
    int          pl_idx = 0;
    logic [31:0] pl_val = '0;

    function automatic int csr_idx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return -1;
        endcase
    endfunction

    always_comb begin
        csr_rdata = 32'hBAD0_0BAD;
        case (csr_addr)
            12'h300: csr_rdata = csr_file[0];
            12'h305: csr_rdata = csr_file[1];
            12'h341: csr_rdata = csr_file[2];
            12'h342: csr_rdata = csr_file[3];
            default: csr_rdata = 32'hBAD0_0BAD;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) csr_file[pl_idx] = pl_val;
        else if (csr_ecall) begin
            csr_file[2] = mepc;
            csr_file[3] = mcause;
        end else if (csr_wen && !csr_mret && csr_idx(csr_addr) >= 0)
            csr_file[csr_idx(csr_addr)] = csr_wdata;
    end

    typedef struct {
        int          done_cyc, wen_cnt, wen_cyc, ecall_cnt, mret_cnt;
        logic [31:0] wdata, mepc, mcause, rd_data, redir_pc;
        logic        rd_wen, redir_valid, illegal;
        bit          timeout, stable, ready_low, ready_offer, ready_after;
    } obs_t;

    typedef struct {
        int          lat, wen_cnt, wen_cyc, ecall_cnt, mret_cnt;
        logic [31:0] wdata, mepc, mcause, rd_data, redir_pc;
        logic        rd_wen, redir_valid, illegal;
    } exp_t;

    obs_t obs;

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        @(posedge clk);
        #1 pl_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Predicts one instruction's observable behaviour straight from the ISA rules.
    task automatic model_instr(input bit e, m, c, input logic [1:0] op, input logic [11:0] addr,
                               input logic [31:0] s1, p, output exp_t x);
        int i;
        logic [31:0] old, nv;
        x = '{default: 0};
        if (e) begin
            x.lat = 2; x.ecall_cnt = 1; x.wen_cnt = 1; x.wen_cyc = 1;
            x.mepc = p; x.mcause = 32'd11; x.redir_valid = 1'b1;
            x.redir_pc = {ref_mem[1][31:2], 2'b00};
            ref_mem[2] = p; ref_mem[3] = 32'd11;
        end else if (m) begin
            x.lat = 2; x.mret_cnt = 1; x.wen_cnt = 1; x.wen_cyc = 1;
            x.redir_valid = 1'b1; x.redir_pc = ref_mem[2];
        end else if (c) begin
            i = csr_idx(addr);
            if (i < 0 || op == 2'b11) begin
                x.lat = 2; x.illegal = 1'b1;
            end else begin
                old = ref_mem[i];
                if (op == 2'b00)      nv = s1;
                else if (op == 2'b01) nv = old | s1;
                else                  nv = old & ~s1;
                x.lat = 3; x.rd_wen = 1'b1; x.rd_data = old;
                if (op == 2'b00 || s1 != 0) begin
                    x.wen_cnt = 1; x.wen_cyc = 2; x.wdata = nv;
                    ref_mem[i] = nv;
                end
            end
        end else begin
            x.lat = 1;
        end
    endtask

    // Offers one instruction, records every strobe and the result, then
    // consumes the result after `hold` stall cycles.
    task automatic run_instr(input bit e, m, c, input logic [1:0] op, input logic [11:0] addr,
                             input logic [31:0] s1, p, input int hold);
        bit found;
        obs = '{default: 0};
        obs.stable = 1; obs.ready_low = 1;
        found = 0;
        @(negedge clk);
        obs.ready_offer = in_ready;
        in_valid = 1'b1; is_ecall = e; is_mret = m; is_csr = c;
        csr_op = op; csr_addr_in = addr; src1 = s1; pc = p;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; is_csr = 1'b0;
            end
            if (in_ready) obs.ready_low = 0;
            if (csr_wen) begin
                obs.wen_cnt++; obs.wen_cyc = k;
                if (!csr_ecall && !csr_mret) obs.wdata = csr_wdata;
            end
            if (csr_ecall) begin
                obs.ecall_cnt++; obs.mepc = mepc; obs.mcause = mcause;
            end
            if (csr_mret) obs.mret_cnt++;
            if (out_valid) begin
                obs.done_cyc = k; obs.rd_wen = rd_wen; obs.rd_data = rd_data;
                obs.redir_valid = redirect_valid; obs.redir_pc = redirect_pc;
                obs.illegal = illegal;
                found = 1;
                break;
            end
        end
        if (!found) begin
            obs.timeout = 1;
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (in_ready || !out_valid || csr_wen || rd_wen !== obs.rd_wen || rd_data !== obs.rd_data ||
                redirect_valid !== obs.redir_valid || redirect_pc !== obs.redir_pc || illegal !== obs.illegal)
                obs.stable = 0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        obs.ready_after = in_ready && !out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        preload(0, 32'h0000_1800);
        preload(1, 32'h0);
        preload(2, 32'h0);
        preload(3, 32'h0);
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if ({out_valid, busy, csr_wen, csr_ecall, csr_mret, rd_wen, redirect_valid, illegal} !== 8'h00) begin
            bad++; $display("FAIL reset_flags got=%b want=00000000",
                            {out_valid, busy, csr_wen, csr_ecall, csr_mret, rd_wen, redirect_valid, illegal});
        end
        total++; if (csr_addr !== 12'h0 || rd_data !== 32'h0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL reset_data got addr=%h rd=%h rpc=%h want zeros", csr_addr, rd_data, redirect_pc);
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_csr_rw();
        preload(1, 32'h0);
        run_instr(0, 0, 1, 2'b00, 12'h305, 32'h8000_0100, 32'h0, 0);
        total++; if (obs.ready_offer !== 1) begin bad++; $display("FAIL rw_ready_offer got=%0d want=1", obs.ready_offer); end
        total++; if (obs.wen_cnt != 1 || obs.wen_cyc != 2) begin
            bad++; $display("FAIL rw_wen got cnt=%0d cyc=%0d want cnt=1 cyc=2", obs.wen_cnt, obs.wen_cyc);
        end
        total++; if (obs.wdata !== 32'h8000_0100) begin bad++; $display("FAIL rw_wdata got=%h want=80000100", obs.wdata); end
        total++; if (obs.done_cyc != 3 || obs.rd_wen !== 1'b1 || obs.rd_data !== 32'h0) begin
            bad++; $display("FAIL rw_result got cyc=%0d rd_wen=%b rd=%h want cyc=3 rd_wen=1 rd=0",
                            obs.done_cyc, obs.rd_wen, obs.rd_data);
        end
        total++; if (csr_file[1] !== 32'h8000_0100) begin bad++; $display("FAIL rw_mtvec got=%h want=80000100", csr_file[1]); end
    endtask

    task automatic test_csr_set();
        preload(0, 32'h0000_1800);
        run_instr(0, 0, 1, 2'b01, 12'h300, 32'h8, 32'h0, 1);
        total++; if (obs.wen_cnt != 1 || obs.wdata !== 32'h1808) begin
            bad++; $display("FAIL rs_write got cnt=%0d wdata=%h want cnt=1 wdata=1808", obs.wen_cnt, obs.wdata);
        end
        total++; if (obs.rd_data !== 32'h1800 || obs.done_cyc != 3) begin
            bad++; $display("FAIL rs_result got rd=%h cyc=%0d want rd=1800 cyc=3", obs.rd_data, obs.done_cyc);
        end
        preload(0, 32'h0000_1800);
        run_instr(0, 0, 1, 2'b01, 12'h300, 32'h0, 32'h0, 0);
        total++; if (obs.wen_cnt != 0) begin bad++; $display("FAIL rs_zero_wen got=%0d want=0", obs.wen_cnt); end
        total++; if (obs.rd_data !== 32'h1800 || obs.rd_wen !== 1'b1) begin
            bad++; $display("FAIL rs_zero_rd got rd=%h rd_wen=%b want rd=1800 rd_wen=1", obs.rd_data, obs.rd_wen);
        end
    endtask

    task automatic test_ecall();
        preload(1, 32'h8000_0103);
        run_instr(1, 0, 0, 2'b00, 12'h0, 32'h0, 32'h8000_0040, 0);
        total++; if (obs.ecall_cnt != 1 || obs.wen_cnt != 1 || obs.wen_cyc != 1) begin
            bad++; $display("FAIL ecall_strobe got ecall=%0d wen=%0d cyc=%0d want 1 1 1", obs.ecall_cnt, obs.wen_cnt, obs.wen_cyc);
        end
        total++; if (obs.mepc !== 32'h8000_0040 || obs.mcause !== 32'd11) begin
            bad++; $display("FAIL ecall_mepc got mepc=%h mcause=%h want 80000040 0000000b", obs.mepc, obs.mcause);
        end
        total++; if (obs.done_cyc != 2 || obs.redir_valid !== 1'b1 || obs.redir_pc !== 32'h8000_0100 || obs.rd_wen !== 1'b0) begin
            bad++; $display("FAIL ecall_result got cyc=%0d rv=%b rpc=%h rd_wen=%b want 2 1 80000100 0",
                            obs.done_cyc, obs.redir_valid, obs.redir_pc, obs.rd_wen);
        end
    endtask

    task automatic test_mret();
        preload(2, 32'h8000_0044);
        run_instr(0, 1, 0, 2'b00, 12'h0, 32'h0, 32'h0, 0);
        total++; if (obs.mret_cnt != 1 || obs.ecall_cnt != 0 || obs.wen_cyc != 1) begin
            bad++; $display("FAIL mret_strobe got mret=%0d ecall=%0d wen_cyc=%0d want 1 0 1", obs.mret_cnt, obs.ecall_cnt, obs.wen_cyc);
        end
        total++; if (obs.done_cyc != 2 || obs.redir_pc !== 32'h8000_0044 || obs.redir_valid !== 1'b1) begin
            bad++; $display("FAIL mret_result got cyc=%0d rpc=%h rv=%b want 2 80000044 1", obs.done_cyc, obs.redir_pc, obs.redir_valid);
        end
        preload(1, 32'h8000_0202);
        run_instr(1, 1, 1, 2'b00, 12'h300, 32'h0, 32'h8000_0010, 0);
        total++; if (obs.ecall_cnt != 1 || obs.mret_cnt != 0 || obs.redir_pc !== 32'h8000_0200) begin
            bad++; $display("FAIL priority got ecall=%0d mret=%0d rpc=%h want 1 0 80000200", obs.ecall_cnt, obs.mret_cnt, obs.redir_pc);
        end
    endtask

    task automatic test_illegal();
        run_instr(0, 0, 1, 2'b00, 12'h7C0, 32'h1234_5678, 32'h0, 5);
        total++; if (obs.illegal !== 1'b1 || obs.done_cyc != 2 || obs.wen_cnt != 0 || obs.rd_wen !== 1'b0 || obs.rd_data !== 32'h0) begin
            bad++; $display("FAIL illegal_addr got ill=%b cyc=%0d wen=%0d rd_wen=%b rd=%h want 1 2 0 0 0",
                            obs.illegal, obs.done_cyc, obs.wen_cnt, obs.rd_wen, obs.rd_data);
        end
        total++; if (!obs.stable || !obs.ready_low) begin
            bad++; $display("FAIL illegal_hold got stable=%0d ready_low=%0d want 1 1", obs.stable, obs.ready_low);
        end
        total++; if (!obs.ready_after) begin bad++; $display("FAIL illegal_ready_after got=0 want=1"); end
        run_instr(0, 0, 1, 2'b11, 12'h300, 32'hFF, 32'h0, 0);
        total++; if (obs.illegal !== 1'b1 || obs.wen_cnt != 0) begin
            bad++; $display("FAIL illegal_op got ill=%b wen=%0d want 1 0", obs.illegal, obs.wen_cnt);
        end
        run_instr(0, 0, 0, 2'b00, 12'h300, 32'h0, 32'h0, 0);
        total++; if (obs.done_cyc != 1 || {obs.rd_wen, obs.redir_valid, obs.illegal} !== 3'b000) begin
            bad++; $display("FAIL noflag got cyc=%0d flags=%b want 1 000", obs.done_cyc, {obs.rd_wen, obs.redir_valid, obs.illegal});
        end
    endtask

    task automatic test_reset_mid();
        preload(0, 32'h0000_1800);
        @(negedge clk);
        in_valid = 1'b1; is_csr = 1'b1; csr_op = 2'b00; csr_addr_in = 12'h300; src1 = 32'h0000_1800;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; is_csr = 1'b0;
        @(negedge clk);
        total++; if (csr_wen !== 1'b1) begin bad++; $display("FAIL mid_write_seen got=%b want=1", csr_wen); end
        rst = 1'b1;
        @(negedge clk);
        total++; if ({csr_wen, csr_ecall, csr_mret, out_valid, busy, in_ready} !== 6'b0) begin
            bad++; $display("FAIL mid_reset got=%b want=000000", {csr_wen, csr_ecall, csr_mret, out_valid, busy, in_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || rd_data !== 32'h0 || csr_addr !== 12'h0) begin
            bad++; $display("FAIL mid_release got ready=%b busy=%b rd=%h addr=%h want 1 0 0 0", in_ready, busy, rd_data, csr_addr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        bit e, m, c;
        logic [1:0] op;
        logic [11:0] addr;
        logic [31:0] s1, p;
        for (int i = 0; i < 4; i++) preload(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            e = ($urandom_range(0, 3) == 0);
            m = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 4) != 0);
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: addr = 12'h300;
                1: addr = 12'h305;
                2: addr = 12'h341;
                3: addr = 12'h342;
                4: addr = 12'h7C0;
                default: addr = 12'($urandom);
            endcase
            s1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            p = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            model_instr(e, m, c, op, addr, s1, p, x);
            run_instr(e, m, c, op, addr, s1, p, $urandom_range(0, 3));
            total++; if (obs.timeout || obs.done_cyc != x.lat) begin
                bad++; $display("FAIL rnd%0d_latency got=%0d timeout=%0d want=%0d", n, obs.done_cyc, obs.timeout, x.lat);
            end
            total++; if (obs.wen_cnt != x.wen_cnt || obs.wen_cyc != x.wen_cyc || obs.wdata !== x.wdata) begin
                bad++; $display("FAIL rnd%0d_write got cnt=%0d cyc=%0d data=%h want cnt=%0d cyc=%0d data=%h",
                                n, obs.wen_cnt, obs.wen_cyc, obs.wdata, x.wen_cnt, x.wen_cyc, x.wdata);
            end
            total++; if (obs.ecall_cnt != x.ecall_cnt || obs.mret_cnt != x.mret_cnt || obs.mepc !== x.mepc || obs.mcause !== x.mcause) begin
                bad++; $display("FAIL rnd%0d_trap got e=%0d m=%0d mepc=%h mcause=%h want e=%0d m=%0d mepc=%h mcause=%h",
                                n, obs.ecall_cnt, obs.mret_cnt, obs.mepc, obs.mcause, x.ecall_cnt, x.mret_cnt, x.mepc, x.mcause);
            end
            total++; if (obs.rd_wen !== x.rd_wen || obs.rd_data !== x.rd_data || obs.illegal !== x.illegal) begin
                bad++; $display("FAIL rnd%0d_rd got wen=%b rd=%h ill=%b want wen=%b rd=%h ill=%b",
                                n, obs.rd_wen, obs.rd_data, obs.illegal, x.rd_wen, x.rd_data, x.illegal);
            end
            total++; if (obs.redir_valid !== x.redir_valid || obs.redir_pc !== x.redir_pc) begin
                bad++; $display("FAIL rnd%0d_redirect got rv=%b rpc=%h want rv=%b rpc=%h",
                                n, obs.redir_valid, obs.redir_pc, x.redir_valid, x.redir_pc);
            end
            total++; if (!obs.ready_offer || !obs.ready_low || !obs.stable || !obs.ready_after) begin
                bad++; $display("FAIL rnd%0d_handshake got offer=%0d low=%0d stable=%0d after=%0d want 1 1 1 1",
                                n, obs.ready_offer, obs.ready_low, obs.stable, obs.ready_after);
            end
            for (int i = 0; i < 4; i++) begin
                total++; if (csr_file[i] !== ref_mem[i]) begin
                    bad++; $display("FAIL rnd%0d_csr%0d got=%h want=%h", n, i, csr_file[i], ref_mem[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_csr_rw();
        test_csr_set();
        test_ecall();
        test_mret();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
